// File: rtl/shield_muxp_seq.sv
// Width-down sequencer: holds one LANES*LANE_W beat and emits it lane by lane on a
// LANE_W valid/ready output. Optional build macro: SHIELD_MUX_SEQ_ZEROIZE_EN.
module shield_muxp_seq #(
   parameter int unsigned LANES  = 8,
   parameter int unsigned LANE_W = 64,
   parameter int unsigned SEL_W  = 3,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [LANES*LANE_W-1:0] in_bus_i,
   input  logic [SEL_W-1:0]        in_last_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [LANE_W-1:0]       out_data_o,
   output logic                    out_last_o,
   output logic [SEL_W-1:0]        mux_sel_o,
   output logic [CNT_W-1:0]        word_cnt_o
);

   typedef enum logic {StIdle, StSend} state_e;

   state_e                  state_q, state_d;
   logic [LANES*LANE_W-1:0] hold_q, hold_d;
   logic [SEL_W-1:0]        last_q, last_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [LANE_W-1:0]       lane_data;
   logic                    is_last;
   logic                    capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         hold_q  <= '0;
         last_q  <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   // Lane mux on the holding register.
   always_comb begin
      lane_data = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (sel_q == SEL_W'(i)) lane_data = hold_q[i*LANE_W +: LANE_W];
      end
   end

   assign is_last     = (state_q == StSend) && (sel_q == last_q);
   assign out_valid_o = (state_q == StSend);
   assign out_last_o  = is_last;
   assign mux_sel_o   = sel_q;
   assign word_cnt_o  = cnt_q;

   // Ready is withheld while reset is asserted so nothing is accepted before release.
   assign in_ready_o = rst_n && ((state_q == StIdle) || (out_ready_i && is_last));
   assign capture    = in_valid_i && in_ready_o;

`ifdef SHIELD_MUX_SEQ_ZEROIZE_EN
   assign out_data_o = (state_q == StSend) ? lane_data : '0;
`else
   assign out_data_o = lane_data;
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (capture) begin
               hold_d  = in_bus_i;
               last_d  = in_last_i;
               sel_d   = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            if (out_ready_i) begin
               cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
               if (!is_last) begin
                  sel_d = sel_q + SEL_W'(1);
               end else begin
                  sel_d = '0;
                  if (capture) begin
                     hold_d = in_bus_i;
                     last_d = in_last_i;
                  end else begin
                     state_d = StIdle;
`ifdef SHIELD_MUX_SEQ_ZEROIZE_EN
                     hold_d  = '0;
`endif
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_shield_muxp_seq.sv
// Randomised and directed bench for shield_muxp_seq against a queue-based word model.
module tb_shield_muxp_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_bus;
   logic [2:0]   in_last;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  out_data;
   logic         out_last;
   logic [2:0]   mux_sel;
   logic [15:0]  word_cnt;

   shield_muxp_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_bus_i   (in_bus),
      .in_last_i  (in_last),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_last_o (out_last),
      .mux_sel_o  (mux_sel),
      .word_cnt_o (word_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [2:0]  lane;
   } word_t;

   word_t exp_q[$];
   int    exp_cnt;
   int    tests;
   int    fails;
   int    cyc;
   int    ready_mode;  // 0: always 1, 1: pattern 1,0,0, 2: random
   bit    accepted;
   bit    out_hs;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock: drive out_ready, compare at negedge, advance model, return at posedge+1.
   task automatic cycle();
      bit exp_ready;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cyc % 3 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      exp_ready = rst_n && (exp_q.size() == 0 || (out_ready && exp_q.size() == 1));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("word_cnt", 64'(word_cnt), 64'(exp_cnt));
      if (exp_q.size() != 0) begin
         chk("out_data", out_data, exp_q[0].data);
         chk("out_last", 64'(out_last), 64'(exp_q[0].last));
         chk("mux_sel", 64'(mux_sel), 64'(exp_q[0].lane));
      end else begin
`ifdef SHIELD_MUX_SEQ_ZEROIZE_EN
         chk("idle_zero", out_data, 64'h0);
`endif
      end
      out_hs   = (exp_q.size() != 0) && out_ready;
      accepted = in_valid && exp_ready;
      if (out_hs) begin
         void'(exp_q.pop_front());
         if (exp_cnt < 65535) exp_cnt++;
      end
      if (accepted) begin
         for (int i = 0; i <= int'(in_last); i++) begin
            word_t w;
            w.data = in_bus[i*64 +: 64];
            w.last = (i == int'(in_last));
            w.lane = 3'(i);
            exp_q.push_back(w);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic offer(input logic [511:0] b, input logic [2:0] l);
      int n = 0;
      in_valid = 1'b1;
      in_bus   = b;
      in_last  = l;
      do begin
         cycle();
         n++;
      end while (!accepted && n < 100);
      if (!accepted) chk("accept_timeout", 64'(n), 64'(0));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      cycle();
   endtask

   function automatic logic [511:0] rand_beat();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   logic [511:0] beat1;
   logic [511:0] beat_ones;
   int           base;

   initial begin
      beat1 = '0;
      beat1[0*64 +: 64] = 64'hdeadbeefdeadbeef;
      beat1[1*64 +: 64] = 64'h10101010ffffffff;
      beat1[7*64 +: 64] = 64'hbbbbbbbbbbbbbbbb;
      beat_ones = {8{64'h1111111111111111}};
      tests = 0; fails = 0; cyc = 0; exp_cnt = 0; ready_mode = 0;
      in_valid = 1'b0; in_bus = '0; in_last = '0; out_ready = 1'b0;

      rst_n = 1'b0;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_last", 64'(out_last), 64'(0));
      chk("rst_mux_sel", 64'(mux_sel), 64'(0));
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_word_cnt", 64'(word_cnt), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      cycle();
      rst_n = 1'b1;
      cycle();

      // Single beat at full throughput.
      offer(beat1, 3'd7);
      drain();
      chk("s1_word_cnt", 64'(word_cnt), 64'(8));
      chk("s1_idle", 64'(out_valid), 64'(0));

      // Backpressure pattern.
      ready_mode = 1;
      offer(beat1, 3'd7);
      drain();
      chk("s2_word_cnt", 64'(word_cnt), 64'(16));
      ready_mode = 0;

      // Back-to-back beats, second accepted on the last word of the first.
      base = exp_cnt;
      offer(beat1, 3'd7);
      offer(beat_ones, 3'd3);
      chk("s3_no_bubble_q", 64'(exp_q.size()), 64'(4));
      drain();
      chk("s3_words", 64'(exp_cnt - base), 64'(12));

      // Single-word beat.
      offer(beat1, 3'd0);
      drain();

      // Reset mid-beat after three words.
      in_valid = 1'b1; in_bus = beat1; in_last = 3'd7;
      cycle();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("s5_pre_cnt", 64'(word_cnt), 64'(exp_cnt));
      rst_n = 1'b0;
      #1;
      chk("s5_out_valid", 64'(out_valid), 64'(0));
      chk("s5_mux_sel", 64'(mux_sel), 64'(0));
      chk("s5_word_cnt", 64'(word_cnt), 64'(0));
      exp_q.delete();
      exp_cnt = 0;
      cycle();
      rst_n = 1'b1;
      cycle();
      offer(beat_ones, 3'd2);
      drain();

      // Randomised traffic.
      ready_mode = 2;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 2) == 0) cycle();
         offer(rand_beat(), 3'($urandom_range(0, 7)));
      end
      drain();
      ready_mode = 0;

      // Counter saturation with back-to-back full beats.
      in_valid = 1'b1;
      in_last  = 3'd7;
      for (int n = 0; n < 66000 && exp_cnt < 65535; n++) begin
         if (accepted) in_bus = rand_beat();
         cycle();
      end
      for (int n = 0; n < 20; n++) cycle();
      in_valid = 1'b0;
      drain();
      chk("sat_word_cnt", 64'(word_cnt), 64'hffff);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
